// File: rtl/morse_keyer_ctrl.sv
// Morse keyer sequencer: times presses and gaps, assembles
// dot/dash symbols into letter codes and flags word gaps.
module morse_keyer_ctrl #(
  parameter int DASH_CLKS       = 3000,
  parameter int LETTER_GAP_CLKS = 3000,
  parameter int WORD_GAP_CLKS   = 7000,
  parameter int MAX_SYMS        = 5,
  parameter int CNT_W           = 16,
  localparam int LW = $clog2(MAX_SYMS + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_i,
  output logic                sym_valid_o,
  output logic                sym_o,
  output logic                letter_valid_o,
  output logic [MAX_SYMS-1:0] code_o,
  output logic [LW-1:0]       len_o,
  output logic                err_o,
  output logic                word_done_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    WORD_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic btn_q;
  logic rise, fall, is_dash;

  logic [MAX_SYMS-1:0] acc_code_q, acc_code_d;
  logic [LW-1:0]       acc_len_q, acc_len_d;
  logic                acc_err_q, acc_err_d;

  logic                sym_valid_d, sym_d;
  logic                letter_valid_d, word_done_d;
  logic [MAX_SYMS-1:0] code_d;
  logic [LW-1:0]       len_d;
  logic                err_d;

  assign rise    = btn_i & ~btn_q;
  assign fall    = ~btn_i & btn_q;
  assign is_dash = cnt_q >= CNT_W'(DASH_CLKS);
  // saturate so a very long hold never wraps into a dot
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_code_d     = acc_code_q;
    acc_len_d      = acc_len_q;
    acc_err_d      = acc_err_q;
    sym_valid_d    = 1'b0;
    sym_d          = sym_o;
    letter_valid_d = 1'b0;
    word_done_d    = 1'b0;
    code_d         = code_o;
    len_d          = len_o;
    err_d          = err_o;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS: begin
        cnt_d = cnt_inc;
        if (fall) begin
          sym_valid_d = 1'b1;
          sym_d       = is_dash;
          state_d     = GAP;
          cnt_d       = CNT_W'(1);
          if (acc_len_q < LW'(MAX_SYMS)) begin
            acc_code_d = acc_code_q
                       | (MAX_SYMS'(is_dash) << acc_len_q);
            acc_len_d  = acc_len_q + 1'b1;
          end else begin
            acc_err_d = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = PRESS;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(LETTER_GAP_CLKS)) begin
          letter_valid_d = 1'b1;
          code_d         = acc_code_q;
          len_d          = acc_len_q;
          err_d          = acc_err_q;
          acc_code_d     = '0;
          acc_len_d      = '0;
          acc_err_d      = 1'b0;
          state_d        = WORD_WAIT;
        end
      end
      WORD_WAIT: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = PRESS;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(WORD_GAP_CLKS)) begin
          word_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      btn_q          <= 1'b0;
      acc_code_q     <= '0;
      acc_len_q      <= '0;
      acc_err_q      <= 1'b0;
      sym_valid_o    <= 1'b0;
      sym_o          <= 1'b0;
      letter_valid_o <= 1'b0;
      code_o         <= '0;
      len_o          <= '0;
      err_o          <= 1'b0;
      word_done_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      btn_q          <= btn_i;
      acc_code_q     <= acc_code_d;
      acc_len_q      <= acc_len_d;
      acc_err_q      <= acc_err_d;
      sym_valid_o    <= sym_valid_d;
      sym_o          <= sym_d;
      letter_valid_o <= letter_valid_d;
      code_o         <= code_d;
      len_o          <= len_d;
      err_o          <= err_d;
      word_done_o    <= word_done_d;
    end
  end

endmodule

// File: doc/morse_keyer_ctrl.md
# morse_keyer_ctrl

Sequencing controller that sits directly behind `debounce`. It takes the debounced key level and times every press and every release. Each press is classified as a dot or a dash, and consecutive symbols are assembled into a letter code. The block emits letter-complete and word-gap events for the downstream Morse lookup/display logic.

## Interface
- `DASH_CLKS`, 3000: press length in cycles at or above which a symbol is a dash; below it the symbol is a dot.
- `LETTER_GAP_CLKS`, 3000: released length in cycles that closes the current letter.
- `WORD_GAP_CLKS`, 7000: released length in cycles that signals a word gap. Must be greater than `LETTER_GAP_CLKS`.
- `MAX_SYMS`, 5: symbol capacity of one letter.
- `CNT_W`, 16: duration counter width. All thresholds must be less than 2^CNT_W−1.
- `clk` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `btn_i` in 1: debounced key level, 1 = pressed.
- `sym_valid_o` out 1: one-cycle pulse per completed symbol.
- `sym_o` out 1: symbol value, 0 = dot, 1 = dash. Valid with `sym_valid_o`.
- `letter_valid_o` out 1: one-cycle pulse when a letter closes.
- `code_o` out MAX_SYMS: letter symbols; symbol i is at bit i (first symbol in bit 0); unused bits are 0.
- `len_o` out $clog2(MAX_SYMS+1): number of symbols stored.
- `err_o` out 1: the letter exceeded `MAX_SYMS`.
- `word_done_o` out 1: one-cycle pulse on a word gap.

## Operation
- `btn_q` is a register holding the previous value of `btn_i`.
  - rise = `btn_i` & ~`btn_q`.
  - fall = ~`btn_i` & `btn_q`.
- `cnt` is a CNT_W-bit counter. It increments every cycle in the PRESS, GAP and WORD_WAIT states and saturates at all-ones.
- States:
  - **IDLE**: on rise → PRESS, `cnt`←1.
  - **PRESS**: on fall → classify. `cnt` ≥ DASH_CLKS → dash, else dot. Then `sym_valid_o`←1, `sym_o`←symbol, → GAP, `cnt`←1. A held key stays in PRESS indefinitely and produces no output.
  - **GAP**:
    - On rise → PRESS, `cnt`←1; the same letter continues.
    - Else if `cnt` == LETTER_GAP_CLKS → `letter_valid_o`←1. `code_o`/`len_o`/`err_o` are loaded from the accumulator, then the accumulator is cleared → WORD_WAIT. `cnt` keeps counting.
  - **WORD_WAIT**:
    - On rise → PRESS, `cnt`←1; a new letter starts and no word pulse is issued.
    - Else if `cnt` == WORD_GAP_CLKS → `word_done_o`←1 → IDLE.
- Accumulator (internal `acc_code`, `acc_len`, `acc_err`), updated on each classified symbol:
  - If `acc_len` < MAX_SYMS: `acc_code`[acc_len]←symbol, `acc_len`+1.
  - Otherwise: `acc_err`←1. The code and length are unchanged, and `sym_valid_o` still pulses.
- `code_o`/`len_o`/`err_o` hold their value between `letter_valid_o` pulses.
- Rise has priority over threshold match in the same cycle.

## Timing
- Reset:
  - All outputs are 0.
  - State is IDLE; `cnt`, `btn_q` and the accumulator are 0.
  - Reset takes effect asynchronously at any time and discards a letter in progress.
- Because `btn_q` resets to 0, a key held high at reset release is detected as a rise in the first clocked cycle.
- Cycle numbering:
  - R is the cycle in which a rise is detected.
  - F is the cycle in which a fall is detected.
  - Press length D = F−R; `cnt` equals D in cycle F.
- `sym_valid_o` is high in cycle F+1 only.
- Letter closure:
  - The letter closes if no rise occurs in cycles F+1 … F+LETTER_GAP_CLKS.
  - `letter_valid_o` is high in cycle F+LETTER_GAP_CLKS+1.
- Word gap:
  - Requires no rise in cycles F+1 … F+WORD_GAP_CLKS.
  - `word_done_o` is high in cycle F+WORD_GAP_CLKS+1.
- All pulses last exactly one cycle. `letter_valid_o` and `word_done_o` are never high together.
- No combinational paths from `btn_i` to any output.

## Test plan
Bench overrides: DASH_CLKS=20, LETTER_GAP_CLKS=30, WORD_GAP_CLKS=70, MAX_SYMS=5.

1. Single dot: press 10 cycles, then release.
   - `sym_valid_o` at F+1 with `sym_o`=0.
   - `letter_valid_o` at F+31 with `code_o`=00000, `len_o`=1, `err_o`=0.
   - `word_done_o` at F+71.
2. Letter "C": presses 25/10/25/10 with 15-cycle gaps.
   - Four `sym_valid_o` pulses with `sym_o` 1,0,1,0.
   - Exactly one `letter_valid_o`, with `code_o`=00101, `len_o`=4.
3. Thresholds:
   - A 19-cycle press gives a dot; a 20-cycle press gives a dash.
   - A rise at F+29, and a rise at F+30, each continue the same letter with no `letter_valid_o`.
   - A rise at F+31 starts a new letter after `letter_valid_o`.
4. Overflow: six dots with 10-cycle gaps.
   - Six `sym_valid_o` pulses.
   - `letter_valid_o` with `len_o`=5, `code_o`=00000, `err_o`=1.
   - The next letter has `err_o`=0.
5. Word gap:
   - A rise at F+50 after a letter yields no `word_done_o`.
   - After the final letter, 70 idle cycles yield exactly one `word_done_o`, and no further pulses follow.
6. Reset mid-letter:
   - Drop `resetn` in PRESS with two symbols accumulated; all outputs are 0 immediately.
   - After release with `btn_i` low, there is no `sym_valid_o`, `letter_valid_o` or `word_done_o`.
